// File: rtl/display_pkg.sv
// Shared definitions for the 3-digit 7-segment display path:
// mode encodings, converter FSM state codes and the hex glyph table.
package display_pkg;

  localparam logic [1:0] MODE_BLANK = 2'b00;
  localparam logic [1:0] MODE_DEC   = 2'b01;
  localparam logic [1:0] MODE_HEX   = 2'b10;
  localparam logic [1:0] MODE_OCT   = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CONV = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Active-high glyphs, bit 0 = segment a .. bit 6 = segment g.
  function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
    logic [6:0] g;
    case (digit)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/display_conv_ctrl_bcd_add3.sv
// One correction cell of the shift-add-3 binary-to-BCD converter:
// a BCD nibble of 5 or more gets 3 added before the next left shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/display_conv_ctrl.sv
// Display front-end: accepts an 8-bit value plus mode, converts it to three
// digits (iterative BCD for decimal, direct slices for hex/octal), holds them
// and scans them onto a shared 7-segment bus.
// Optional build macro: LEADING_ZERO_BLANK_EN darkens leading zero digits.
//
// Handshake: a transfer happens on a rising edge where in_valid and in_ready
// are both 1. in_ready is 1 only in IDLE (and never while rst is high);
// in_valid while busy is ignored. out_valid is a one-cycle pulse marking the
// cycle right after the digit registers were loaded.
module display_conv_ctrl
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] A,
  input  logic [1:0] sel,
  output logic       out_valid,
  output logic [3:0] dig_u,
  output logic [3:0] dig_d,
  output logic [3:0] dig_c,
  output logic [2:0] blank,
  output logic [6:0] seg,
  output logic [2:0] an
);

  state_t      state;
  logic [7:0]  a_sh;     // latched value; shifted out MSB-first in decimal mode
  logic [1:0]  mode_q;
  logic [9:0]  bcd;      // {hundreds[1:0], tens[3:0], units[3:0]}
  logic [3:0]  step;
  logic [3:0]  units_adj;
  logic [3:0]  tens_adj;
  logic [3:0]  nxt_u;
  logic [3:0]  nxt_d;
  logic [3:0]  nxt_c;
  logic [2:0]  nxt_blank;
  logic [31:0] presc;
  logic [3:0]  scan_digit;
  logic        scan_dark;

  // Hundreds never exceeds 2, so only units and tens need correction.
  bcd_add3 u_add_units (.din(bcd[3:0]), .dout(units_adj));
  bcd_add3 u_add_tens  (.din(bcd[7:4]), .dout(tens_adj));

  assign in_ready = (state == ST_IDLE) && !rst;

  // Digit values and blanking that the DONE state will load.
  always_comb begin
    nxt_u     = 4'd0;
    nxt_d     = 4'd0;
    nxt_c     = 4'd0;
    nxt_blank = 3'b111;
    case (mode_q)
      MODE_DEC: begin
        nxt_u = bcd[3:0];
        nxt_d = bcd[7:4];
        nxt_c = {2'b00, bcd[9:8]};
      end
      MODE_HEX: begin
        nxt_u = a_sh[3:0];
        nxt_d = a_sh[7:4];
      end
      MODE_OCT: begin
        nxt_u = {1'b0, a_sh[2:0]};
        nxt_d = {1'b0, a_sh[5:3]};
        nxt_c = {2'b00, a_sh[7:6]};
      end
      default: ;
    endcase
    if (mode_q != MODE_BLANK) begin
`ifdef LEADING_ZERO_BLANK_EN
      nxt_blank = {nxt_c == 4'd0, (nxt_c == 4'd0) && (nxt_d == 4'd0), 1'b0};
`else
      nxt_blank = 3'b000;
`endif
    end
  end

  // Converter FSM: accept, run 8 shift-add-3 steps for decimal, load digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_sh      <= 8'd0;
      mode_q    <= MODE_BLANK;
      bcd       <= 10'd0;
      step      <= 4'd0;
      out_valid <= 1'b0;
      dig_u     <= 4'd0;
      dig_d     <= 4'd0;
      dig_c     <= 4'd0;
      blank     <= 3'b111;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh   <= A;
            mode_q <= sel;
            bcd    <= 10'd0;
            step   <= 4'd0;
            state  <= (sel == MODE_DEC) ? ST_CONV : ST_DONE;
          end
        end
        ST_CONV: begin
          bcd  <= {bcd[8], tens_adj, units_adj, a_sh[7]};
          a_sh <= {a_sh[6:0], 1'b0};
          step <= step + 4'd1;
          if (step == 4'd7) state <= ST_DONE;
        end
        ST_DONE: begin
          dig_u     <= nxt_u;
          dig_d     <= nxt_d;
          dig_c     <= nxt_c;
          blank     <= nxt_blank;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Free-running scan: rotate the digit enable every SCAN_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= 32'd0;
      an    <= 3'b001;
    end else if (presc == SCAN_DIV - 1) begin
      presc <= 32'd0;
      an    <= {an[1:0], an[2]};
    end else begin
      presc <= presc + 32'd1;
    end
  end

  // Segment pattern of whichever digit the scan currently enables.
  always_comb begin
    scan_digit = dig_u;
    scan_dark  = blank[0];
    case (an)
      3'b010: begin
        scan_digit = dig_d;
        scan_dark  = blank[1];
      end
      3'b100: begin
        scan_digit = dig_c;
        scan_dark  = blank[2];
      end
      default: ;
    endcase
    seg = scan_dark ? 7'd0 : seg_glyph(scan_digit);
  end

endmodule

// File: tb/tb_display_conv_ctrl.sv
// Self-checking bench for display_conv_ctrl (SCAN_DIV = 4).
module tb_display_conv_ctrl;
  import display_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] A = 8'd0;
  logic [1:0] sel = 2'd0;
  logic       out_valid;
  logic [3:0] dig_u, dig_d, dig_c;
  logic [2:0] blank;
  logic [6:0] seg;
  logic [2:0] an;

  display_conv_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .sel(sel), .out_valid(out_valid), .dig_u(dig_u), .dig_d(dig_d),
    .dig_c(dig_c), .blank(blank), .seg(seg), .an(an)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [14:0] exp_q[$];   // {c, d, u, blank}
  int          acc_q[$];   // edge index of acceptance
  int          elat_q[$];  // expected accept -> out_valid latency

  logic [6:0] glyph_t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] model(input logic [7:0] a, input logic [1:0] m);
    int v;
    logic [3:0] c, d, u;
    logic [2:0] b;
    v = int'(a);
    c = 4'd0; d = 4'd0; u = 4'd0;
    case (m)
      MODE_DEC: begin c = 4'(v / 100); d = 4'((v / 10) % 10); u = 4'(v % 10); end
      MODE_HEX: begin d = 4'(v / 16); u = 4'(v % 16); end
      MODE_OCT: begin c = 4'(v / 64); d = 4'((v / 8) % 8); u = 4'(v % 8); end
      default: ;
    endcase
    if (m == MODE_BLANK) b = 3'b111;
`ifdef LEADING_ZERO_BLANK_EN
    else b = {c == 4'd0, (c == 4'd0) && (d == 4'd0), 1'b0};
`else
    else b = 3'b000;
`endif
    return {c, d, u, b};
  endfunction

  // scan reference: free-running divide-by-4 rotation of the digit enable
  int         m_pre = 0;
  logic [2:0] m_an = 3'b001;
  always @(posedge clk) begin
    if (rst) begin
      m_pre <= 0;
      m_an  <= 3'b001;
    end else if (m_pre == 3) begin
      m_pre <= 0;
      m_an  <= {m_an[1:0], m_an[2]};
    end else begin
      m_pre <= m_pre + 1;
    end
  end

  // driver: present a value, wait (bounded) for acceptance, then release
  task automatic send(input logic [7:0] a, input logic [1:0] m, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    A = a; sel = m; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    if (push) begin
      exp_q.push_back(model(a, m));
      acc_q.push_back(cyc + 1);
      elat_q.push_back((m == MODE_DEC) ? 9 : 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard: compare every out_valid pulse against the oldest expectation
  logic [14:0] mon_e;
  int          mon_k, mon_l;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_k = acc_q.pop_front();
        mon_l = elat_q.pop_front();
        check("dig_c", 32'(dig_c), 32'(mon_e[14:11]));
        check("dig_d", 32'(dig_d), 32'(mon_e[10:7]));
        check("dig_u", 32'(dig_u), 32'(mon_e[6:3]));
        check("blank", 32'(blank), 32'(mon_e[2:0]));
        check("latency", 32'(cyc - mon_k), 32'(mon_l));
      end
    end
  end

  initial begin
    // reset held for two cycles
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_blank", 32'(blank), 32'b111);
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_an", 32'(an), 32'b001);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_digs", {20'd0, dig_c, dig_d, dig_u}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // decimal corner values and the other modes
    send(8'hFF, MODE_DEC, 1'b1);
    send(8'd0, MODE_DEC, 1'b1);
    send(8'd100, MODE_DEC, 1'b1);
    send(8'hC5, MODE_OCT, 1'b1);
    send(8'hA7, MODE_HEX, 1'b1);
    send(8'hA7, MODE_BLANK, 1'b1);
    wait_drain();
    @(negedge clk);
    check("blank_mode_seg", 32'(seg), 32'd0);
    send(8'd7, MODE_DEC, 1'b1);
    wait_drain();

    // in_valid pulsed during conversion must be ignored
    send(8'd123, MODE_DEC, 1'b1);
    @(negedge clk);
    A = 8'd55; sel = MODE_HEX; in_valid = 1'b1;
    check("ready_in_conv", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);

    // reset at conversion step 4 aborts with no output
    send(8'd200, MODE_DEC, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_digs", {20'd0, dig_c, dig_d, dig_u}, 32'd0);
    check("abort_blank", 32'(blank), 32'b111);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    repeat (15) @(negedge clk);

    // scan of digits 2/5/5
    send(8'd255, MODE_DEC, 1'b1);
    wait_drain();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("scan_an", 32'(an), 32'(m_an));
      check("scan_seg", 32'(seg), 32'(m_an == 3'b100 ? glyph_t[2] : glyph_t[5]));
    end

    // random mixed traffic, back to back
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'b1);
    end
    wait_drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
